pingpong_frame_buffer: RTL
==========================

Name: pingpong_frame_buffer

Overview:
Parametrised, single-clock, double-buffered (ping-pong) frame store placed between the camera pixel capture path and the display/processing read path. The writer fills one bank while the reader randomly addresses the last completed frame in the other bank. Banks swap only on frame completion and reader release, so the reader never sees a torn frame. Memory is inferred block RAM with a registered read.

Parameters:
DATA_W, 8, pixel word width
DEPTH, 4096, words per frame (per bank); must be >= 2 and <= 2**ADDR_W
ADDR_W, 12, pixel address width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  pixel strobe from capture
wr_sof  in  1  start of frame; qualified by wr_valid, marks pixel 0
wr_data  in  DATA_W  pixel data
wr_blocked  out  1  completed frame pending; writer refusing new frames
frame_ready  out  1  reader holds a complete frame in bank rbank
rd_release  in  1  one-cycle pulse: reader done with the held frame
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address within the held frame
rd_data  out  DATA_W  registered read data
rd_valid  out  1  rd_data valid this cycle

Behaviour:
- Storage: 2*DEPTH words, physical address {bank, pixel_addr}. Contents are not cleared by reset.
- Reset, asynchronous: wr_blocked=0, frame_ready=0, rd_valid=0, rd_data=0, wbank=0, rbank=1, wr_ptr=0, writer state WAIT_SOF.
- Writer FSM:
  - WAIT_SOF: wr_valid&wr_sof writes mem[wbank,0], sets wr_ptr=1, moves to FILL. wr_valid without sof is ignored.
  - FILL: wr_valid&!wr_sof writes mem[wbank,wr_ptr] and increments wr_ptr. wr_valid&wr_sof aborts the frame, writes the pixel at address 0, sets wr_ptr=1, and stays in FILL. The write at address DEPTH-1 completes the frame (see Swap).
  - BLOCKED: all wr_valid pixels are dropped, with or without sof. No memory writes.
- Swap on frame completion, evaluated the cycle after the write at DEPTH-1:
  - If frame_ready=0, or rd_release is asserted the same cycle: rbank<=wbank, wbank<=~wbank, frame_ready=1, writer goes to WAIT_SOF.
  - Otherwise: writer goes to BLOCKED and wr_blocked=1.
- rd_release behaviour:
  - While frame_ready=1 and writer BLOCKED: rbank<=wbank, wbank<=~wbank, frame_ready stays 1, wr_blocked<=0, writer goes to WAIT_SOF.
  - While frame_ready=1 and not BLOCKED: frame_ready<=0 next cycle.
  - While frame_ready=0: ignored.
- Invariant: wbank != rbank whenever frame_ready=1.
- Read: rd_en&frame_ready with rd_addr<DEPTH gives rd_valid=1 and rd_data=mem[rbank,rd_addr] one cycle later. Latency is exactly 1, full throughput.
  - rd_en with frame_ready=0 or rd_addr>=DEPTH: rd_valid=0 next cycle and rd_data holds its previous value.
  - A read in the same cycle as a rbank swap uses the old rbank.
- wr_ptr is ADDR_W bits and never exceeds DEPTH-1; there is no wrap, because completion leaves FILL.
- Reset mid-frame discards the partial frame and any held or pending frame.

Optional Feature:
Macro FB_DROP_CNT_EN.
- Defined: adds output port drop_cnt (16 bits, reset 0). It increments by 1 for each wr_sof&wr_valid received in BLOCKED and for each mid-frame abort in FILL. It saturates at 16'hFFFF and is cleared only by rst.
- Undefined: drop_cnt port and its logic are absent. All other behaviour is identical.

Test Plan:
- DEPTH=16, write frame A (data 0x00..0x0F, sof on first) -> frame_ready=1 the cycle after the 16th pixel, wbank=1, rbank=0. Reading addr 5 returns 0x05 with rd_valid one cycle after rd_en.
- With frame A held, write frame B (0x10..0x1F) -> wr_blocked=1. Reading addr 3 still returns 0x03. Frame C pixels are dropped (drop_cnt=1 with FB_DROP_CNT_EN). rd_release -> addr 3 returns 0x13 and wr_blocked=0.
- Held frame, no pending: rd_release -> frame_ready=0 next cycle. rd_en then gives rd_valid=0 and rd_data unchanged.
- Frame completion in the same cycle as rd_release -> no block; rbank flips and frame_ready stays 1.
- sof at pixel 7 of a frame -> restart at address 0. Completion occurs 16 pixels after the restart. drop_cnt increments (macro on).
- Assert rst while in FILL and while BLOCKED -> all outputs return to reset values immediately (asynchronously). A following full frame behaves as the first test.

Source files
------------

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store: writer fills one bank, reader addresses the other.
// Optional FB_DROP_CNT_EN adds a saturating count of dropped/aborted frames.
module pingpong_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic              wr_sof,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_blocked,
  output logic              frame_ready,
  input  logic              rd_release,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
`ifdef FB_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  typedef enum logic [1:0] {
    WAIT_SOF,
    FILL,
    BLOCKED
  } wstate_e;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  logic [DATA_W-1:0] mem_q [2*DEPTH];

  wstate_e           st_q, st_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic              ready_q, ready_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              drop_inc;
  logic              done;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  function automatic logic [ADDR_W:0] phys(
    input logic              bank,
    input logic [ADDR_W-1:0] a
  );
    return {1'b0, a} + (bank ? DEPTH_X : '0);
  endfunction

  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    ready_d  = ready_q;
    we       = 1'b0;
    waddr    = '0;
    drop_inc = 1'b0;
    done     = 1'b0;
    unique case (st_q)
      WAIT_SOF: begin
        if (wr_valid && wr_sof) begin
          we       = 1'b1;
          wr_ptr_d = ADDR_W'(1);
          st_d     = FILL;
        end
      end
      FILL: begin
        if (wr_valid && wr_sof) begin
          we       = 1'b1;
          wr_ptr_d = ADDR_W'(1);
          drop_inc = 1'b1;
        end else if (wr_valid) begin
          we    = 1'b1;
          waddr = wr_ptr_q;
          if (wr_ptr_q == LAST) begin
            done     = 1'b1;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      BLOCKED: begin
        drop_inc = wr_valid && wr_sof;
      end
      default: st_d = WAIT_SOF;
    endcase
    // a finished frame either swaps in at once or waits for the reader
    if (done) begin
      if (!ready_q || rd_release) begin
        rbank_d = wbank_q;
        wbank_d = ~wbank_q;
        ready_d = 1'b1;
        st_d    = WAIT_SOF;
      end else begin
        st_d = BLOCKED;
      end
    end else if (ready_q && rd_release) begin
      if (st_q == BLOCKED) begin
        rbank_d = wbank_q;
        wbank_d = ~wbank_q;
        st_d    = WAIT_SOF;
      end else begin
        ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= WAIT_SOF;
      wr_ptr_q <= '0;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      wr_ptr_q <= wr_ptr_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[phys(wbank_q, waddr)] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (rd_en && ready_q && ({1'b0, rd_addr} < DEPTH_X)) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= mem_q[phys(rbank_q, rd_addr)];
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign wr_blocked  = (st_q == BLOCKED);
  assign frame_ready = ready_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;

`ifdef FB_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_inc && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop_inc;
`endif

endmodule
